// File: rtl/event_encoder_16x4.sv
`default_nettype none
// ============================================================================
//  Module      : event_encoder_16x4
//  Description : Sequential N-to-log2(N) event encoder. Event strobes on W are
//                captured into a sticky pending register and serialized as
//                binary codes on a valid/ready handshake.
//                Build option: define ROUND_ROBIN_EN for rotating priority
//                (search starts after the last accepted code); otherwise the
//                lowest pending index wins.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset
//                En       - capture enable for W
//                W        - event strobes, W[i] maps to code i
//                Y        - registered code being offered
//                valid    - Y holds a code, held until accepted
//                ready    - sink accepts Y when valid & ready at an edge
//                pending  - sticky pending-event register
//                overflow - sticky flag: an event was lost to coalescing
//  Revision    : 1.0 - initial release
// ============================================================================
module event_encoder_16x4 #(
  parameter int N      = 16,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic [N-1:0]      W,
  output logic [CODE_W-1:0] Y,
  output logic              valid,
  input  logic              ready,
  output logic [N-1:0]      pending,
  output logic              overflow
);

  // Reject unsupported configurations at elaboration time.
  if ((CODE_W != $clog2(N)) || (N < 4) || (N > 16) || ((N & (N - 1)) != 0)) begin : g_param_check
    $error("event_encoder_16x4: N must be a power of two in 4..16 and CODE_W must equal log2(N)");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CODE_W-1:0] y_nxt;
  logic              valid_nxt;
  logic [CODE_W-1:0] sel;
  logic              accept;
  logic [N-1:0]      clr;
  logic [N-1:0]      pending_nxt;
  logic              lost;

  // valid is only ever high in OFFER, so this is the handshake completion.
  assign accept = valid & ready;
  assign clr    = accept ? (N'(1) << Y) : '0;

  // Set wins over clear: W is OR-ed in after the accepted bit is removed.
  always_comb begin
    pending_nxt = pending & ~clr;
    lost        = 1'b0;
    if (En) begin
      pending_nxt = pending_nxt | W;
      lost        = |(W & pending & ~clr);
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_acc <= CODE_W'(N - 1);
    end else if (accept) begin
      last_acc <= Y;
    end
  end

  // Search starts one past the last accepted code and wraps naturally,
  // since N is exactly 2**CODE_W.
  always_comb begin
    logic [CODE_W-1:0] idx;
    logic              found;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = last_acc + CODE_W'(k) + CODE_W'(1);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index in sel.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel = CODE_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    valid_nxt = valid;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (pending != '0) begin
          y_nxt     = sel;
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        // Y is frozen here; new events only accumulate in pending.
        if (accept) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      Y        <= '0;
      valid    <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      Y        <= y_nxt;
      valid    <= valid_nxt;
      pending  <= pending_nxt;
      overflow <= overflow | lost;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_16x4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_encoder_16x4
//  Description : Directed self-checking bench for event_encoder_16x4 in its
//                default fixed-priority build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder_16x4;

  logic        clk = 1'b0;
  logic        rst;
  logic        En;
  logic [15:0] W;
  logic [3:0]  Y;
  logic        valid;
  logic        ready;
  logic [15:0] pending;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  event_encoder_16x4 #(.N(16), .CODE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .En       (En),
    .W        (W),
    .Y        (Y),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with all strobes high
    rst = 1'b1; En = 1'b1; W = 16'hFFFF; ready = 1'b0;
    step();
    step();
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_Y", 32'(Y), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    rst = 1'b0; W = 16'h0000;
    step();
    chk("post_rst_pending", 32'(pending), 32'h0);

    // 2. Single event, code 5
    W = 16'h0020; ready = 1'b1;
    step();
    chk("single_pending", 32'(pending), 32'h0020);
    chk("single_valid_early", 32'(valid), 32'h0);
    W = 16'h0000;
    step();
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_Y", 32'(Y), 32'h5);
    step();
    chk("single_drain_valid", 32'(valid), 32'h0);
    chk("single_drain_pending", 32'(pending), 32'h0);

    // 3. Multi-hot 8101 -> 0, 8, 15 with a bubble between codes
    W = 16'h8101;
    step();
    W = 16'h0000;
    step();
    chk("multi_Y0", 32'(Y), 32'h0);
    chk("multi_v0", 32'(valid), 32'h1);
    step();
    chk("multi_bubble0", 32'(valid), 32'h0);
    chk("multi_pend0", 32'(pending), 32'h8100);
    step();
    chk("multi_Y1", 32'(Y), 32'h8);
    chk("multi_v1", 32'(valid), 32'h1);
    step();
    chk("multi_bubble1", 32'(valid), 32'h0);
    step();
    chk("multi_Y2", 32'(Y), 32'hF);
    chk("multi_v2", 32'(valid), 32'h1);
    step();
    chk("multi_end_valid", 32'(valid), 32'h0);
    chk("multi_end_pending", 32'(pending), 32'h0);

    // 4. Backpressure: code 3 held while code 1 arrives
    ready = 1'b0; W = 16'h0008;
    step();
    W = 16'h0000;
    step();
    chk("bp_Y_first", 32'(Y), 32'h3);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) W = 16'h0002;
      step();
      W = 16'h0000;
      chk("bp_hold_Y", 32'(Y), 32'h3);
      chk("bp_hold_valid", 32'(valid), 32'h1);
    end
    chk("bp_pending", 32'(pending), 32'h000A);
    ready = 1'b1;
    step();
    chk("bp_accept_valid", 32'(valid), 32'h0);
    chk("bp_accept_pending", 32'(pending), 32'h0002);
    step();
    chk("bp_next_Y", 32'(Y), 32'h1);
    chk("bp_next_valid", 32'(valid), 32'h1);
    step();
    chk("bp_end_pending", 32'(pending), 32'h0);

    // 5a. Coalescing sets overflow, only one code 4 issued
    ready = 1'b0; W = 16'h0010;
    step();
    chk("ovf_first_capture", 32'(overflow), 32'h0);
    step();
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_Y", 32'(Y), 32'h4);
    step();
    W = 16'h0000; ready = 1'b1;
    step();
    chk("ovf_accept_valid", 32'(valid), 32'h0);
    chk("ovf_accept_pending", 32'(pending), 32'h0);
    step();
    chk("ovf_single_code", 32'(valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // 5b. Strobe on the accept edge re-issues without overflow
    rst = 1'b1;
    step();
    chk("ovf_cleared_by_rst", 32'(overflow), 32'h0);
    rst = 1'b0; ready = 1'b0; W = 16'h0010;
    step();
    W = 16'h0000;
    step();
    chk("reissue_Y", 32'(Y), 32'h4);
    ready = 1'b1; W = 16'h0010;
    step();
    W = 16'h0000;
    chk("reissue_pending_kept", 32'(pending), 32'h0010);
    chk("reissue_no_overflow", 32'(overflow), 32'h0);
    chk("reissue_bubble", 32'(valid), 32'h0);
    step();
    chk("reissue_valid", 32'(valid), 32'h1);
    chk("reissue_Y2", 32'(Y), 32'h4);
    step();
    chk("reissue_end_pending", 32'(pending), 32'h0);

    // 6. Reset in the middle of an offer
    ready = 1'b0; W = 16'h0080;
    step();
    W = 16'h0100;
    step();
    W = 16'h0000;
    chk("mid_Y", 32'(Y), 32'h7);
    chk("mid_pending", 32'(pending), 32'h0180);
    rst = 1'b1; ready = 1'b1;
    step();
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_pending", 32'(pending), 32'h0);
    rst = 1'b0; En = 1'b0; W = 16'hFFFF;
    step();
    step();
    chk("en0_valid", 32'(valid), 32'h0);
    chk("en0_pending", 32'(pending), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
